// File: rtl/sync_fifo_cfg_pkg.sv
// Shared constants and read-mode type for the configurable synchronous FIFO.
package sync_fifo_cfg_pkg;

    localparam int DWIDTH_DEF    = 16;
    localparam int AWIDTH_DEF    = 3;
    localparam int AFULL_TH_DEF  = 6;
    localparam int AEMPTY_TH_DEF = 1;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } rd_mode_e;

endpackage

// File: rtl/sync_fifo_cfg_dpram.sv
// Dual-port storage array: synchronous write port, asynchronous read port.
module fifo_dpram #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem_r [2**AWIDTH];

    // Write port; contents are deliberately not reset, pointers hide stale data
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_cfg.sv
// Synchronous FIFO with configurable width, depth, thresholds and read mode
// (standard registered read or first-word-fall-through).
module sync_fifo_cfg
    import sync_fifo_cfg_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int AWIDTH    = AWIDTH_DEF,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = AFULL_TH_DEF,
    parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wren,
    input  logic              rden,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              afull,
    output logic              aempty,
    output logic [AWIDTH:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] PTR_ONE   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH:0] DEPTH_V   = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] AFULL_V   = AFULL_TH[AWIDTH:0];
    localparam logic [AWIDTH:0] AEMPTY_V  = AEMPTY_TH[AWIDTH:0];
    localparam rd_mode_e        MODE      = (FWFT != 0) ? sync_fifo_cfg_pkg::FWFT
                                                        : sync_fifo_cfg_pkg::STD;

    if (AWIDTH < 1) begin : g_bad_awidth
        $error("sync_fifo_cfg: AWIDTH must be at least 1");
    end
    if (DWIDTH < 1) begin : g_bad_dwidth
        $error("sync_fifo_cfg: DWIDTH must be at least 1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("sync_fifo_cfg: FWFT must be 0 or 1");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_cfg: AFULL_TH out of range 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_cfg: AEMPTY_TH out of range 0..DEPTH-1");
    end

    logic [AWIDTH:0]   wr_ptr_r, rd_ptr_r, count_r;
    logic [AWIDTH:0]   wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
    logic              wr_acc_s, rd_acc_s;
    logic              full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
    logic [DWIDTH-1:0] rdata_s, dout_r;

    fifo_dpram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[AWIDTH-1:0]),
        .wdata (din),
        .raddr (rd_ptr_r[AWIDTH-1:0]),
        .rdata (rdata_s)
    );

    // Acceptance decisions and next pointer/occupancy values
    always_comb begin
        wr_acc_s = wren & ~full_r;
        rd_acc_s = rden & ~empty_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Pointers, flags, error pulses and the standard-mode read register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {(AWIDTH+1){1'b0}};
            rd_ptr_r <= {(AWIDTH+1){1'b0}};
            count_r  <= {(AWIDTH+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
            dout_r   <= {DWIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_V);
            empty_r  <= (count_nxt_s == {(AWIDTH+1){1'b0}});
            afull_r  <= (count_nxt_s >= AFULL_V);
            aempty_r <= (count_nxt_s <= AEMPTY_V);
            ovf_r    <= wren & full_r;
            udf_r    <= rden & empty_r;
            if (rd_acc_s) begin
                dout_r <= rdata_s;
            end
        end
    end

    // In FWFT mode the head entry is shown straight from the array
    assign dout   = (MODE == sync_fifo_cfg_pkg::FWFT) ? rdata_s : dout_r;
    assign full   = full_r;
    assign empty  = empty_r;
    assign afull  = afull_r;
    assign aempty = aempty_r;
    assign count  = count_r;
    assign ovf    = ovf_r;
    assign udf    = udf_r;

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Directed bench driving a standard-mode and an FWFT-mode FIFO with identical stimulus.
module tb_sync_fifo_cfg;

    logic        clk;
    logic        rstn;
    logic        wren;
    logic        rden;
    logic [15:0] din;

    logic [15:0] s_dout, f_dout;
    logic        s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [3:0]  s_count, f_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] q[$];
    logic [15:0] w;
    logic [15:0] popped;

    sync_fifo_cfg #(.DWIDTH(16), .AWIDTH(3), .FWFT(0), .AFULL_TH(6), .AEMPTY_TH(1)) u_std (
        .clk(clk), .rstn(rstn), .wren(wren), .rden(rden), .din(din),
        .dout(s_dout), .full(s_full), .empty(s_empty), .afull(s_afull),
        .aempty(s_aempty), .count(s_count), .ovf(s_ovf), .udf(s_udf)
    );

    sync_fifo_cfg #(.DWIDTH(16), .AWIDTH(3), .FWFT(1), .AFULL_TH(6), .AEMPTY_TH(1)) u_fwft (
        .clk(clk), .rstn(rstn), .wren(wren), .rden(rden), .din(din),
        .dout(f_dout), .full(f_full), .empty(f_empty), .afull(f_afull),
        .aempty(f_aempty), .count(f_count), .ovf(f_ovf), .udf(f_udf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Occupancy and the four level flags of both instances for occupancy n
    task automatic chk_occ(input string tag, input int n);
        chk({tag, " s_count"},  32'(s_count),  32'(n));
        chk({tag, " f_count"},  32'(f_count),  32'(n));
        chk({tag, " s_full"},   32'(s_full),   32'(n == 8));
        chk({tag, " f_full"},   32'(f_full),   32'(n == 8));
        chk({tag, " s_empty"},  32'(s_empty),  32'(n == 0));
        chk({tag, " f_empty"},  32'(f_empty),  32'(n == 0));
        chk({tag, " s_afull"},  32'(s_afull),  32'(n >= 6));
        chk({tag, " f_afull"},  32'(f_afull),  32'(n >= 6));
        chk({tag, " s_aempty"}, 32'(s_aempty), 32'(n <= 1));
        chk({tag, " f_aempty"}, 32'(f_aempty), 32'(n <= 1));
    endtask

    task automatic chk_err(input string tag, input logic o, input logic u);
        chk({tag, " s_ovf"}, 32'(s_ovf), 32'(o));
        chk({tag, " f_ovf"}, 32'(f_ovf), 32'(o));
        chk({tag, " s_udf"}, 32'(s_udf), 32'(u));
        chk({tag, " f_udf"}, 32'(f_udf), 32'(u));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        wren = 1'b0;
        rden = 1'b0;
        din  = 16'h0000;
        #23;
        chk_occ("reset", 0);
        chk_err("reset", 1'b0, 1'b0);
        chk("reset s_dout", 32'(s_dout), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Fill with 1..8, first write on the first edge after reset release
        for (int i = 1; i <= 8; i++) begin
            din  = 16'(i);
            wren = 1'b1;
            step();
            chk_occ($sformatf("fill%0d", i), i);
        end

        // Write into a full FIFO is rejected
        din = 16'hDEAD;
        step();
        chk_occ("ovf", 8);
        chk_err("ovf", 1'b1, 1'b0);
        wren = 1'b0;
        step();
        chk_err("ovf_end", 1'b0, 1'b0);
        chk_occ("ovf_end", 8);

        // Full with write+read: read accepted, write rejected
        chk("fw head1", 32'(f_dout), 32'h0001);
        wren = 1'b1;
        rden = 1'b1;
        din  = 16'hDEAD;
        step();
        chk_occ("full_wr", 7);
        chk_err("full_wr", 1'b1, 1'b0);
        chk("full_wr s_dout", 32'(s_dout), 32'h0001);
        wren = 1'b0;

        // Drain the remaining 2..8 in order
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("drain%0d f_dout", i), 32'(f_dout), 32'(i));
            rden = 1'b1;
            step();
            chk($sformatf("drain%0d s_dout", i), 32'(s_dout), 32'(i));
            chk_occ($sformatf("drain%0d", i), 8 - i);
        end
        rden = 1'b0;
        step();
        chk("hold s_dout", 32'(s_dout), 32'h0008);
        chk_err("drained", 1'b0, 1'b0);

        // Read from empty is rejected
        rden = 1'b1;
        step();
        chk_occ("udf", 0);
        chk_err("udf", 1'b0, 1'b1);
        chk("udf s_dout", 32'(s_dout), 32'h0008);
        rden = 1'b0;
        step();
        chk_err("udf_end", 1'b0, 1'b0);

        // Empty with write+read: write accepted, read rejected
        wren = 1'b1;
        rden = 1'b1;
        din  = 16'h1234;
        step();
        chk_occ("empty_wr", 1);
        chk_err("empty_wr", 1'b0, 1'b1);
        chk("empty_wr f_dout", 32'(f_dout), 32'h1234);
        wren = 1'b0;
        step();
        chk("empty_wr s_dout", 32'(s_dout), 32'h1234);
        chk_occ("empty_wr_rd", 0);
        rden = 1'b0;

        // Fall-through timing of a single word
        wren = 1'b1;
        din  = 16'hBEEF;
        step();
        wren = 1'b0;
        chk_occ("beef", 1);
        chk("beef f_dout", 32'(f_dout), 32'hBEEF);
        rden = 1'b1;
        step();
        rden = 1'b0;
        chk("beef s_dout", 32'(s_dout), 32'hBEEF);
        chk_occ("beef_rd", 0);

        // Streaming at occupancy 3: 50 simultaneous write+read cycles
        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom_range(0, 65535));
            q.push_back(w);
            din  = w;
            wren = 1'b1;
            step();
        end
        wren = 1'b0;
        chk_occ("pre_stream", 3);
        for (int i = 0; i < 50; i++) begin
            w = 16'($urandom_range(0, 65535));
            chk($sformatf("stream%0d f_dout", i), 32'(f_dout), 32'(q[0]));
            q.push_back(w);
            din  = w;
            wren = 1'b1;
            rden = 1'b1;
            step();
            popped = q.pop_front();
            chk($sformatf("stream%0d s_dout", i), 32'(s_dout), 32'(popped));
            chk($sformatf("stream%0d s_count", i), 32'(s_count), 32'd3);
            chk($sformatf("stream%0d f_count", i), 32'(f_count), 32'd3);
            chk_err($sformatf("stream%0d", i), 1'b0, 1'b0);
        end
        wren = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("tail%0d f_dout", i), 32'(f_dout), 32'(q[0]));
            step();
            popped = q.pop_front();
            chk($sformatf("tail%0d s_dout", i), 32'(s_dout), 32'(popped));
        end
        rden = 1'b0;
        chk_occ("stream_end", 0);

        // Reset in the middle of a cycle discards stored entries
        for (int i = 0; i < 5; i++) begin
            din  = 16'h0100 + 16'(i);
            wren = 1'b1;
            step();
        end
        wren = 1'b0;
        chk_occ("pre_rst", 5);
        #2;
        rstn = 1'b0;
        #1;
        chk_occ("mid_rst", 0);
        chk_err("mid_rst", 1'b0, 1'b0);
        chk("mid_rst s_dout", 32'(s_dout), 32'h0);
        #1;
        rstn = 1'b1;
        din  = 16'hA5A5;
        wren = 1'b1;
        step();
        wren = 1'b0;
        chk_occ("post_rst_wr", 1);
        chk("post_rst f_dout", 32'(f_dout), 32'hA5A5);
        rden = 1'b1;
        step();
        rden = 1'b0;
        chk("post_rst s_dout", 32'(s_dout), 32'hA5A5);
        chk_occ("post_rst_rd", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_cfg.md
SYNC_FIFO_CFG -- requirements
Module: sync_fifo_cfg

Interface
REQ-001 Parameter DWIDTH, default 16, SHALL set the data word width in bits.
REQ-002 Parameter AWIDTH, default 3, SHALL set the address width; DEPTH = 2**AWIDTH entries.
REQ-003 Parameter FWFT, default 0, SHALL select the read mode: 0 = standard, 1 = first-word-fall-through.
REQ-004 Parameter AFULL_TH, default 6, SHALL set the almost-full threshold, legal range 1..DEPTH.
REQ-005 Parameter AEMPTY_TH, default 1, SHALL set the almost-empty threshold, legal range 0..DEPTH-1.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 wren  input  1  SHALL be the write request.
REQ-009 rden  input  1  SHALL be the read request (pop in FWFT mode).
REQ-010 din  input  DWIDTH  SHALL be the write data.
REQ-011 dout  output  DWIDTH  SHALL be the read data.
REQ-012 full, empty  output  1 each  SHALL be the occupancy-equal-to-DEPTH and occupancy-zero flags.
REQ-013 afull, aempty  output  1 each  SHALL be the almost-full and almost-empty flags.
REQ-014 count  output  AWIDTH+1  SHALL be the current occupancy, 0..DEPTH.
REQ-015 ovf, udf  output  1 each  SHALL be the one-cycle overflow and underflow error pulses.

Function
REQ-016 Write SHALL be accepted when wren=1 and full=0; din is stored at wr_ptr and wr_ptr increments.
REQ-017 Read SHALL be accepted when rden=1 and empty=0; rd_ptr increments.
REQ-018 Pointers SHALL be AWIDTH+1 bits wide, with the MSB as the wrap bit; the memory index is the low AWIDTH bits; wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-019 count SHALL equal wr_ptr - rd_ptr, modulo 2**(AWIDTH+1), after each edge.
REQ-020 full/empty/afull/aempty SHALL be registered and reflect the count after the edge: afull = count>=AFULL_TH; aempty = count<=AEMPTY_TH.
REQ-021 Accepted write and read in the same cycle SHALL leave count unchanged.
REQ-022 When full and wren=rden=1: the read SHALL be accepted, the write rejected, and ovf pulsed.
REQ-023 When empty and wren=rden=1: the write SHALL be accepted, the read rejected, and udf pulsed.
REQ-024 ovf SHALL pulse for one cycle on any rejected write; udf SHALL pulse for one cycle on any rejected read; neither SHALL alter pointers or memory.
REQ-025 FWFT=0: dout SHALL update one cycle after an accepted read with the popped word, and hold its value otherwise.
REQ-026 FWFT=1: dout SHALL present the head entry combinationally from the memory whenever empty=0; an accepted read exposes the next entry in the following cycle.
REQ-027 FWFT=1: the first word written into an empty FIFO SHALL be visible on dout in the cycle empty deasserts, one cycle after the write.
REQ-028 FWFT=1 and empty=1: dout SHALL be don't-care; benches SHALL NOT check it.

Reset
REQ-029 rstn=0 SHALL immediately clear wr_ptr, rd_ptr, count, dout, full, afull, ovf, and udf to 0, and set empty and aempty to 1.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; memory contents are not reset and SHALL be unobservable until rewritten.
REQ-031 The first write SHALL be accepted on the first rising edge with rstn=1.

Structure
REQ-032 Package sync_fifo_cfg_pkg SHALL hold the default DWIDTH/AWIDTH/threshold constants and the read-mode enum (STD, FWFT).
REQ-033 Storage SHALL be the sub-module fifo_dpram: a synchronous-write, asynchronous-read dual-port array parametrised by DWIDTH/AWIDTH.
REQ-034 Pointer/flag logic and the dout register SHALL live in sync_fifo_cfg; parameter legality SHALL be checked at elaboration.

Verification (DWIDTH=16, AWIDTH=3, both FWFT values)
REQ-035 Write 0x0001..0x0008 back-to-back, then read all 8 -> full=1 and count=8 after the 8th write; afull asserts after the 6th write; data returns in order; empty=1 at the end.
REQ-036 With the FIFO full, assert wren=1, rden=0 with din=0xDEAD -> ovf=1 for one cycle; count stays 8; 0xDEAD never read.
REQ-037 With the FIFO empty, assert rden=1 -> udf=1 for one cycle; count stays 0; pointers unchanged.
REQ-038 50 random words with simultaneous write+read at occupancy 3 -> count constant at 3, order preserved, pointers wrap more than 6 times with no error.
REQ-039 FWFT=1: write 0xBEEF into an empty FIFO -> next cycle empty=0 and dout=0xBEEF with no read issued; FWFT=0: dout=0xBEEF one cycle after rden.
REQ-040 Write 5 words, pulse rstn low mid-cycle -> flags return to reset values immediately, count=0, and the next write/read returns only the new data.
